// File: rtl/dsp_slice_pkg.sv
// Shared DSP slice definitions: ALU mode codes and default datapath width.
// No ports; imported by the ALU core, P-stage top and interface.
package dsp_slice_pkg;

    localparam int DSP_WIDTH = 48;

    localparam logic [3:0] ALU_ADD     = 4'b0000;
    localparam logic [3:0] ALU_NZ_ADD  = 4'b0001;
    localparam logic [3:0] ALU_NOT_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB     = 4'b0011;
    localparam logic [3:0] ALU_XOR     = 4'b0100;
    localparam logic [3:0] ALU_XNOR    = 4'b0101;
    localparam logic [3:0] ALU_AND     = 4'b1100;
    localparam logic [3:0] ALU_OR      = 4'b1101;

endpackage

// File: rtl/dsp_alu_preg_if.sv
// Operand/control and result bundle of the ALU + P-register stage.
// master: drives RSTP/CEP/mode/operands, reads results; slave: the stage.
interface dsp_alu_preg_if
    import dsp_slice_pkg::*;
#(
    parameter int WIDTH = DSP_WIDTH
);
    logic             RSTP;
    logic             CEP;
    logic [3:0]       ALU_MODE_IN;
    logic [WIDTH-1:0] X;
    logic [WIDTH-1:0] Y;
    logic [WIDTH-1:0] Z;
    logic             CIN;
    logic [WIDTH-1:0] PATTERN;
    logic [WIDTH-1:0] MASK;
    logic [WIDTH-1:0] P;
    logic             CARRYOUT;
    logic             ALUMODE_ERR;
    logic             PATTERNDETECT;
    logic             PATTERNBDETECT;
    logic             OVERFLOW;
    logic             UNDERFLOW;

    modport master (
        output RSTP, CEP, ALU_MODE_IN, X, Y, Z, CIN, PATTERN, MASK,
        input  P, CARRYOUT, ALUMODE_ERR,
        input  PATTERNDETECT, PATTERNBDETECT, OVERFLOW, UNDERFLOW
    );

    modport slave (
        input  RSTP, CEP, ALU_MODE_IN, X, Y, Z, CIN, PATTERN, MASK,
        output P, CARRYOUT, ALUMODE_ERR,
        output PATTERNDETECT, PATTERNBDETECT, OVERFLOW, UNDERFLOW
    );

endinterface

// File: rtl/dsp_alu_core.sv
// Combinational post-multiplier ALU: (mode, X, Y, Z, CIN) -> (r, c, err).
// Ports: mode, x, y, z, cin in; r result, c carry/not-borrow, err bad mode.
module dsp_alu_core
    import dsp_slice_pkg::*;
#(
    parameter int WIDTH = DSP_WIDTH
) (
    input  logic [3:0]       mode,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [WIDTH-1:0] z,
    input  logic             cin,
    output logic [WIDTH-1:0] r,
    output logic             c,
    output logic             err
);

    logic [WIDTH-1:0] xy;
    logic [WIDTH:0]   sum;

    assign xy = x + y + {{(WIDTH-1){1'b0}}, cin};

    always_comb begin
        r   = '0;
        c   = 1'b0;
        err = 1'b0;
        sum = '0;
        unique case (mode)
            ALU_ADD: begin
                sum = {1'b0, z} + {1'b0, xy};
                r   = sum[WIDTH-1:0];
                c   = sum[WIDTH];
            end
            ALU_NZ_ADD: begin
                sum = {1'b0, ~z} + {1'b0, xy};
                r   = sum[WIDTH-1:0];
                c   = sum[WIDTH];
            end
            ALU_NOT_ADD: begin
                sum = {1'b0, z} + {1'b0, xy};
                r   = ~sum[WIDTH-1:0];
                c   = sum[WIDTH];
            end
            ALU_SUB: begin
                // carry out of Z + ~XY + 1 is the not-borrow flag
                sum = {1'b0, z} + {1'b0, ~xy} + {{WIDTH{1'b0}}, 1'b1};
                r   = sum[WIDTH-1:0];
                c   = sum[WIDTH];
            end
            ALU_XOR:  r = x ^ z;
            ALU_XNOR: r = ~(x ^ z);
            ALU_AND:  r = x & z;
            ALU_OR:   r = x | z;
            default: begin
                sum = {1'b0, z} + {1'b0, xy};
                r   = sum[WIDTH-1:0];
                c   = sum[WIDTH];
                err = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/dsp_alu_preg.sv
// ALU + P output register stage of the DSP slice; PREG selects reg/bypass.
// Ports: CLK, RST_N (async low), bus (slave). Option: PATTERN_DETECT_EN.
module dsp_alu_preg
    import dsp_slice_pkg::*;
#(
    parameter int WIDTH = DSP_WIDTH,
    parameter bit PREG  = 1'b1
) (
    input  logic        CLK,
    input  logic        RST_N,
    dsp_alu_preg_if.slave bus
);

    logic [WIDTH-1:0] r;
    logic             c;
    logic             err;

    dsp_alu_core #(.WIDTH(WIDTH)) u_core (
        .mode (bus.ALU_MODE_IN),
        .x    (bus.X),
        .y    (bus.Y),
        .z    (bus.Z),
        .cin  (bus.CIN),
        .r    (r),
        .c    (c),
        .err  (err)
    );

    if (PREG) begin : g_preg
        logic [WIDTH-1:0] p_q;
        logic             c_q;
        logic             err_q;

        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                p_q   <= '0;
                c_q   <= 1'b0;
                err_q <= 1'b0;
            end else if (bus.RSTP) begin
                p_q   <= '0;
                c_q   <= 1'b0;
                err_q <= 1'b0;
            end else if (bus.CEP) begin
                p_q   <= r;
                c_q   <= c;
                err_q <= err;
            end
        end

        assign bus.P           = p_q;
        assign bus.CARRYOUT    = c_q;
        assign bus.ALUMODE_ERR = err_q;
    end else begin : g_bypass
        assign bus.P           = r;
        assign bus.CARRYOUT    = c;
        assign bus.ALUMODE_ERR = err;
    end

`ifdef PATTERN_DETECT_EN
    logic pd_now;
    logic pbd_now;
    logic pd_out;
    logic pbd_out;
    logic pd_past;
    logic pbd_past;

    assign pd_now  = ((r ^ bus.PATTERN) & ~bus.MASK) == '0;
    assign pbd_now = ((r ^ ~bus.PATTERN) & ~bus.MASK) == '0;

    if (PREG) begin : g_pd_reg
        logic pd_q;
        logic pbd_q;

        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                pd_q  <= 1'b0;
                pbd_q <= 1'b0;
            end else if (bus.RSTP) begin
                pd_q  <= 1'b0;
                pbd_q <= 1'b0;
            end else if (bus.CEP) begin
                pd_q  <= pd_now;
                pbd_q <= pbd_now;
            end
        end

        assign pd_out  = pd_q;
        assign pbd_out = pbd_q;
    end else begin : g_pd_comb
        assign pd_out  = pd_now;
        assign pbd_out = pbd_now;
    end

    // history always samples the flag value currently presented
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pd_past  <= 1'b0;
            pbd_past <= 1'b0;
        end else if (bus.RSTP) begin
            pd_past  <= 1'b0;
            pbd_past <= 1'b0;
        end else if (bus.CEP) begin
            pd_past  <= pd_out;
            pbd_past <= pbd_out;
        end
    end

    assign bus.PATTERNDETECT  = pd_out;
    assign bus.PATTERNBDETECT = pbd_out;
    assign bus.OVERFLOW       = pd_past & ~pd_out & ~pbd_out;
    assign bus.UNDERFLOW      = pbd_past & ~pd_out & ~pbd_out;
`else
    assign bus.PATTERNDETECT  = 1'b0;
    assign bus.PATTERNBDETECT = 1'b0;
    assign bus.OVERFLOW       = 1'b0;
    assign bus.UNDERFLOW      = 1'b0;
`endif

endmodule

// File: tb/tb_dsp_alu_preg.sv
// Bench for dsp_alu_preg: PREG=1 and PREG=0 instances vs a reference model.
// Directed literal checks plus randomized operands, modes and resets.
module tb_dsp_alu_preg;
    import dsp_slice_pkg::*;

    localparam longint unsigned M = (64'd1 << 48) - 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        rstp = 1'b0;
    logic        cep = 1'b1;
    logic [3:0]  mode = 4'd0;
    logic [47:0] x = '0;
    logic [47:0] y = '0;
    logic [47:0] z = '0;
    logic        cin = 1'b0;
    logic [47:0] pat = '0;
    logic [47:0] msk = '1;

    int checks = 0;
    int failures = 0;

    dsp_alu_preg_if #(.WIDTH(48)) bus1 ();
    dsp_alu_preg_if #(.WIDTH(48)) bus0 ();

    assign bus1.RSTP = rstp;
    assign bus1.CEP = cep;
    assign bus1.ALU_MODE_IN = mode;
    assign bus1.X = x;
    assign bus1.Y = y;
    assign bus1.Z = z;
    assign bus1.CIN = cin;
    assign bus1.PATTERN = pat;
    assign bus1.MASK = msk;
    assign bus0.RSTP = rstp;
    assign bus0.CEP = cep;
    assign bus0.ALU_MODE_IN = mode;
    assign bus0.X = x;
    assign bus0.Y = y;
    assign bus0.Z = z;
    assign bus0.CIN = cin;
    assign bus0.PATTERN = pat;
    assign bus0.MASK = msk;

    dsp_alu_preg #(.WIDTH(48), .PREG(1'b1)) dut1 (
        .CLK (clk), .RST_N (rst_n), .bus (bus1)
    );
    dsp_alu_preg #(.WIDTH(48), .PREG(1'b0)) dut0 (
        .CLK (clk), .RST_N (rst_n), .bus (bus0)
    );

    always #5 clk = ~clk;

    task automatic check(input string name,
                         input longint unsigned act,
                         input longint unsigned exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic void alu_ref(input logic [3:0] md,
                                    input longint unsigned a,
                                    input longint unsigned b,
                                    input longint unsigned zz,
                                    input bit ci,
                                    output longint unsigned res,
                                    output bit co,
                                    output bit er);
        longint unsigned xy;
        longint unsigned s;
        xy = (a + b + longint'(ci)) & M;
        er = 1'b0;
        co = 1'b0;
        case (md)
            4'd1: begin res = (xy - zz - 1) & M; co = xy > zz; end
            4'd2: begin s = zz + xy; res = ~s & M; co = s > M; end
            4'd3: begin res = (zz - xy) & M; co = zz >= xy; end
            4'd4: res = a ^ zz;
            4'd5: res = ~(a ^ zz) & M;
            4'd12: res = a & zz;
            4'd13: res = a | zz;
            default: begin
                s = zz + xy;
                res = s & M;
                co = s > M;
                er = (md != 4'd0);
            end
        endcase
    endfunction

    function automatic bit pd_of(input longint unsigned res);
`ifdef PATTERN_DETECT_EN
        return ((res ^ pat) & ~msk & M) == 0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit pbd_of(input longint unsigned res);
`ifdef PATTERN_DETECT_EN
        return ((res ^ (~pat & M)) & ~msk & M) == 0;
`else
        return 1'b0;
`endif
    endfunction

    // model state: registered stage (e_*) and bypass-instance history (z_*)
    longint unsigned e_p = 0;
    bit e_c = 0, e_err = 0, e_pd = 0, e_pbd = 0, e_pdp = 0, e_pbdp = 0;
    bit z_pdp = 0, z_pbdp = 0;

    always @(posedge clk or negedge rst_n) begin
        longint unsigned res;
        bit co, er;
        if (!rst_n || rstp) begin
            e_p <= 0; e_c <= 0; e_err <= 0;
            e_pd <= 0; e_pbd <= 0; e_pdp <= 0; e_pbdp <= 0;
            z_pdp <= 0; z_pbdp <= 0;
        end else if (cep) begin
            alu_ref(mode, x, y, z, cin, res, co, er);
            e_pdp <= e_pd;
            e_pbdp <= e_pbd;
            e_p <= res;
            e_c <= co;
            e_err <= er;
            e_pd <= pd_of(res);
            e_pbd <= pbd_of(res);
            z_pdp <= pd_of(res);
            z_pbdp <= pbd_of(res);
        end
    end

    always @(negedge clk) begin
        longint unsigned res;
        bit co, er, pd, pbd;
        check("preg1",
              {bus1.P, bus1.CARRYOUT, bus1.ALUMODE_ERR,
               bus1.PATTERNDETECT, bus1.PATTERNBDETECT,
               bus1.OVERFLOW, bus1.UNDERFLOW},
              {e_p[47:0], e_c, e_err, e_pd, e_pbd,
               e_pdp & ~e_pd & ~e_pbd, e_pbdp & ~e_pd & ~e_pbd});
        alu_ref(mode, x, y, z, cin, res, co, er);
        pd = pd_of(res);
        pbd = pbd_of(res);
        check("preg0",
              {bus0.P, bus0.CARRYOUT, bus0.ALUMODE_ERR,
               bus0.PATTERNDETECT, bus0.PATTERNBDETECT,
               bus0.OVERFLOW, bus0.UNDERFLOW},
              {res[47:0], co, er, pd, pbd,
               z_pdp & ~pd & ~pbd, z_pbdp & ~pd & ~pbd});
    end

    function automatic logic [47:0] r48();
        return 48'({$urandom, $urandom});
    endfunction

    logic [3:0] modes [10] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4,
                               4'd5, 4'd12, 4'd13, 4'd10, 4'd7};

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            x = r48(); y = r48(); z = r48(); mode = 4'd0; cep = 1'b1;
            cyc();
            check("rst_p", bus1.P, 0);
            check("rst_co", bus1.CARRYOUT, 0);
            #1;
        end
        rst_n = 1'b1;
        mode = ALU_ADD; z = 48'hFFFF_FFFF_FFFF; x = 48'd1; y = '0; cin = 0;
        cyc();
        check("add_wrap_p", bus1.P, 0);
        check("add_wrap_co", bus1.CARRYOUT, 1);
        #1 mode = ALU_SUB; z = 48'd5; x = 48'd7;
        cyc();
        check("sub_neg_p", bus1.P, 48'hFFFF_FFFF_FFFE);
        check("sub_neg_co", bus1.CARRYOUT, 0);
        #1 z = 48'd7; x = 48'd5;
        cyc();
        check("sub_pos_p", bus1.P, 2);
        check("sub_pos_co", bus1.CARRYOUT, 1);
        #1 rstp = 1'b1;
        cyc();
        check("rstp_p", bus1.P, 0);
        #1 rstp = 1'b0; mode = ALU_ADD; x = 48'd3;
        for (int i = 1; i <= 4; i++) begin
            z = e_p[47:0];
            cyc();
            check("acc_p", bus1.P, 3 * i);
            #1;
        end
        cep = 1'b0;
        for (int i = 0; i < 2; i++) begin
            z = e_p[47:0];
            cyc();
            check("hold_p", bus1.P, 12);
            #1;
        end
        rstp = 1'b1;
        cyc();
        check("rstp_nocep_p", bus1.P, 0);
        #1 rstp = 1'b0; cep = 1'b1;
        mode = ALU_AND; x = 48'hF0F0; z = 48'hFF00;
        cyc();
        check("and_p", bus1.P, 48'hF000);
        check("and_co", bus1.CARRYOUT, 0);
        #1 mode = 4'b1010; x = 48'd1; z = 48'd1; y = '0; cin = 0;
        cyc();
        check("bad_p", bus1.P, 2);
        check("bad_err", bus1.ALUMODE_ERR, 1);
        #1 pat = '0; msk = ~48'hF; mode = ALU_ADD; x = '0; z = '0;
        cyc();
`ifdef PATTERN_DETECT_EN
        check("pd_zero", bus1.PATTERNDETECT, 1);
`endif
        #1 x = 48'd5;
        #1 check("bypass_p", bus0.P, 5);
        cyc();
`ifdef PATTERN_DETECT_EN
        check("pd_five", bus1.PATTERNDETECT, 0);
        check("ovf_five", bus1.OVERFLOW, 1);
`endif
        #1;
        for (int n = 0; n < 500; n++) begin
            mode = modes[$urandom_range(9)];
            if ($urandom_range(1) == 0) begin
                x = 48'($urandom_range(255));
                y = 48'($urandom_range(255));
                z = 48'($urandom_range(255));
            end else begin
                x = r48(); y = r48(); z = r48();
            end
            if ($urandom_range(3) == 0) z = e_p[47:0];
            cin = 1'($urandom_range(1));
            pat = 48'($urandom_range(255));
            msk = ~48'($urandom_range(255));
            cep = ($urandom_range(7) != 0);
            rstp = ($urandom_range(15) == 0);
            rst_n = ($urandom_range(63) != 0);
            cyc();
            #1;
        end
        rst_n = 1'b1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
